volt_bcd_disp: RTL
==================

# volt_bcd_disp

Display-side stage downstream of the voltage quantizer. It samples the 12-bit amplitude code at a fixed refresh rate and scales it to millivolts. An iterative double-dabble engine then converts the value to four BCD digits for the digit-tube / LCD driver. It provides a decimal readout and holds it stable between refreshes.

## Interface
- `REFRESH_CNT`, default 5_000_000: clk cycles between sample ticks (100 ms at 50 MHz). Must be ≥ 32.
- `SCALE_MUL`, default 1611: millivolt scale multiplier, 16-bit unsigned.
- `SCALE_SHIFT`, default 9: right shift applied after the multiply.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `volt_in`, input, 12: amplitude code from the quantizer, unsigned, continuously driven.
- `hold`, input, 1: freeze the display; sample ticks are ignored while high.
- `bcd_thou`, output, 4: thousands digit (mV).
- `bcd_hund`, output, 4: hundreds digit.
- `bcd_tens`, output, 4: tens digit.
- `bcd_ones`, output, 4: ones digit.
- `ovf`, output, 1: last conversion was clamped to 9999.
- `bcd_valid`, output, 1: one-cycle pulse when the digit outputs update.

## Operation
- Refresh counter `rcnt` (32-bit) counts 0..REFRESH_CNT-1 and wraps. `tick` = (rcnt == REFRESH_CNT-1). The counter runs regardless of state or `hold`.
- FSM states: IDLE, MULT, CLAMP, SHIFT, DONE.
  - IDLE: on `tick` && !`hold`, latch `volt_in` into `vreg` and go to MULT. Otherwise stay in IDLE.
  - MULT: `prod` = `vreg` × `SCALE_MUL`, 28-bit unsigned, registered. Go to CLAMP.
  - CLAMP: `mv` = `prod` >> `SCALE_SHIFT` (truncating).
    - If `mv` > 9999: load 9999 and set `ovf_n`=1.
    - Otherwise: load `mv[13:0]` and set `ovf_n`=0.
    - Load the 14-bit shift source, clear the 16-bit BCD accumulator, set `bitcnt`=13, go to SHIFT.
  - SHIFT: one double-dabble iteration per cycle.
    - Add 3 to each BCD nibble that is ≥ 5.
    - Shift {bcd, src} left by 1.
    - When `bitcnt`==0, go to DONE. Otherwise decrement `bitcnt`. 14 iterations total.
  - DONE: register the four nibbles to the outputs, set `ovf` from `ovf_n`, pulse `bcd_valid`, return to IDLE.
- `tick` arriving in any state other than IDLE is dropped; there is no queuing.
- `volt_in` changes after the latch cycle have no effect on the conversion in flight.
- `hold` rising mid-conversion does not abort it; the conversion completes and the display updates once.
- Outputs change only in DONE. Between updates they hold their last value.

## Timing
- Reset (`rst`=1 at a clk edge): FSM→IDLE, `rcnt`=0, digits=0, `ovf`=0, `bcd_valid`=0, internal registers=0.
- Reset asserted mid-conversion aborts it; outputs return to 0 on the same edge.
- Latency: with `tick` at edge T (latch), MULT runs at T+1 and CLAMP at T+2. SHIFT occupies T+3..T+16 and DONE is at T+17. Outputs and the `bcd_valid` pulse are visible after edge T+17.
- The first tick after reset occurs REFRESH_CNT-1 cycles after reset release.
- Conversion busy window is 18 cycles, which is why `REFRESH_CNT` must be ≥ 32.

## Structure
- Shared package `disp_pkg`:
  - FSM state encoding (3-bit)
  - `MV_MAX` = 14'd9999
  - `BCD_DIGITS` = 4
  - `MV_W` = 14
- Sub-module `bin2bcd_dd`: the iterative double-dabble engine. Ports: clk, rst, start, bin[13:0], busy, done, bcd[15:0]. The parent FSM drives `start` from CLAMP and waits on `done`.
- The multiplier is inferred as a single registered DSP multiply.

## Test plan
- Use `REFRESH_CNT`=32. `volt_in`=0 → after first tick + 17 cycles, digits 0/0/0/0, `ovf`=0, one `bcd_valid` pulse.
- `volt_in`=1000 → 3146 mV: digits 3/1/4/6, `ovf`=0.
- `volt_in`=3178 → 9999, `ovf`=0. `volt_in`=3179 → 9999, `ovf`=1. `volt_in`=4095 → 9999, `ovf`=1.
- Latch `volt_in`=1000, then drive `volt_in`=4095 at T+1 → result 3/1/4/6. The next tick yields 9999 with `ovf`=1.
- `hold`=1 across three ticks → no `bcd_valid` pulse and digits unchanged. `hold` dropped → next tick updates the digits.
- Assert `rst` at T+8 mid-SHIFT → all outputs 0 on the next edge, no `bcd_valid`. The next conversion after release completes normally.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the voltage display path: FSM encoding, BCD sizing
// and the double-dabble nibble adjust used by the conversion engine.
package disp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMult,
    StClamp,
    StShift,
    StDone
  } disp_state_e;

  localparam logic [13:0] MV_MAX     = 14'd9999;
  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned MV_W       = 14;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  // Add 3 to every nibble that is >= 5 so the following left shift carries
  // correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dd_adjust(logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Iterative double-dabble converter: 14-bit binary to four BCD digits,
// one shift per clock, 14 iterations after start.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   start_i - load bin_i and begin a conversion
//   bin_i   - binary value to convert (<= 9999)
//   busy_o  - conversion in progress
//   done_o  - high during the final iteration; bcd_o is final the cycle after
//   bcd_o   - BCD accumulator {thou, hund, tens, ones}
module bin2bcd_dd
  import disp_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [MV_W-1:0]   bin_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [BCD_W-1:0]  bcd_o
);

  logic              busy_q, busy_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [MV_W-1:0]   src_q, src_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  adj;

  always_comb begin
    adj      = dd_adjust(bcd_q);
    busy_d   = busy_q;
    bitcnt_d = bitcnt_q;
    src_d    = src_q;
    bcd_d    = bcd_q;
    if (start_i) begin
      src_d    = bin_i;
      bcd_d    = '0;
      bitcnt_d = 4'd13;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      {bcd_d, src_d} = {adj[BCD_W-2:0], src_q, 1'b0};
      if (bitcnt_q == 4'd0) begin
        busy_d = 1'b0;
      end else begin
        bitcnt_d = bitcnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      bitcnt_q <= '0;
      src_q    <= '0;
      bcd_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      bitcnt_q <= bitcnt_d;
      src_q    <= src_d;
      bcd_q    <= bcd_d;
    end
  end

  // Flag the last iteration so the parent can step to DONE on the same edge
  // that completes the conversion.
  assign done_o = busy_q && (bitcnt_q == 4'd0);
  assign busy_o = busy_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/volt_bcd_disp.sv
// Periodically samples the quantizer code, scales it to millivolts, clamps
// to 9999 and converts to four BCD digits held stable between refreshes.
// Ports:
//   clk_i        - system clock
//   rst_i        - synchronous active-high reset
//   volt_in_i    - 12-bit amplitude code
//   hold_i       - ignore sample ticks while high
//   bcd_thou_o.. - displayed digits (mV)
//   ovf_o        - last conversion was clamped
//   bcd_valid_o  - one-cycle pulse when digits update
module volt_bcd_disp
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_CNT = 5_000_000,
  parameter int unsigned SCALE_MUL   = 1611,
  parameter int unsigned SCALE_SHIFT = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] volt_in_i,
  input  logic        hold_i,
  output logic [3:0]  bcd_thou_o,
  output logic [3:0]  bcd_hund_o,
  output logic [3:0]  bcd_tens_o,
  output logic [3:0]  bcd_ones_o,
  output logic        ovf_o,
  output logic        bcd_valid_o
);

  localparam logic [31:0] RcntLast = 32'(REFRESH_CNT - 1);
  localparam logic [15:0] ScaleMul = 16'(SCALE_MUL);

  disp_state_e       state_q, state_d;
  logic [31:0]       rcnt_q, rcnt_d;
  logic [11:0]       vreg_q, vreg_d;
  logic [27:0]       prod_q, prod_d;
  logic              ovf_n_q, ovf_n_d;
  logic [BCD_W-1:0]  digits_q, digits_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;

  logic              tick;
  logic [27:0]       mv;
  logic [MV_W-1:0]   mv_sel;
  logic              eng_start, eng_busy, eng_done;
  logic [BCD_W-1:0]  eng_bcd;

  assign tick   = (rcnt_q == RcntLast);
  assign rcnt_d = tick ? 32'd0 : rcnt_q + 32'd1;

  assign mv        = prod_q >> SCALE_SHIFT;
  assign mv_sel    = (mv > 28'(MV_MAX)) ? MV_MAX : mv[MV_W-1:0];
  assign eng_start = (state_q == StClamp) && !eng_busy;

  bin2bcd_dd u_bin2bcd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (eng_start),
    .bin_i   (mv_sel),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .bcd_o   (eng_bcd)
  );

  always_comb begin
    state_d  = state_q;
    vreg_d   = vreg_q;
    prod_d   = prod_q;
    ovf_n_d  = ovf_n_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (tick && !hold_i) begin
          vreg_d  = volt_in_i;
          state_d = StMult;
        end
      end
      StMult: begin
        prod_d  = 28'(vreg_q) * 28'(ScaleMul);
        state_d = StClamp;
      end
      StClamp: begin
        ovf_n_d = (mv > 28'(MV_MAX));
        state_d = StShift;
      end
      StShift: begin
        if (eng_done) state_d = StDone;
      end
      StDone: begin
        digits_d = eng_bcd;
        ovf_d    = ovf_n_q;
        valid_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      rcnt_q   <= '0;
      vreg_q   <= '0;
      prod_q   <= '0;
      ovf_n_q  <= 1'b0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      vreg_q   <= vreg_d;
      prod_q   <= prod_d;
      ovf_n_q  <= ovf_n_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign {bcd_thou_o, bcd_hund_o, bcd_tens_o, bcd_ones_o} = digits_q;
  assign ovf_o       = ovf_q;
  assign bcd_valid_o = valid_q;

endmodule
